// File: rtl/led_seq_ctrl.sv
// Pattern sequencer for the 4-bit LED bank: req/ack mode loading, prescaled stepping.
// Optional PWM dimming is enabled by defining LED_PWM_DIM_EN.
module led_seq_ctrl #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int STEP_HZ  = 4,
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                mode_req,
    input  logic [1:0]          mode,
`ifdef LED_PWM_DIM_EN
    input  logic [PWM_BITS-1:0] duty,
`endif
    output logic                mode_ack,
    output logic                busy,
    output logic [3:0]          led
);

    localparam int DIV   = CLK_HZ / STEP_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_BLINK = 2'd2;
    localparam logic [1:0] S_COUNT = 2'd3;

    if (DIV < 1) begin : g_div_chk
        $error("led_seq_ctrl: CLK_HZ/STEP_HZ must be at least 1");
    end
    if (PWM_BITS < 1) begin : g_pwm_chk
        $error("led_seq_ctrl: PWM_BITS must be at least 1");
    end

    logic [1:0]       r_state;
    logic [3:0]       r_pattern;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ack;
    logic             r_busy;
    logic [3:0]       r_led;

    logic [1:0]       w_state_nxt;
    logic [3:0]       w_pattern_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_ack_nxt;
    logic [3:0]       w_led_mask;
    logic             w_accept;
    logic             w_tick;

    function automatic logic [1:0] mode_to_state(input logic [1:0] m);
        case (m)
            2'd1:    mode_to_state = S_SHIFT;
            2'd2:    mode_to_state = S_BLINK;
            2'd3:    mode_to_state = S_COUNT;
            default: mode_to_state = S_IDLE;
        endcase
    endfunction

    function automatic logic [3:0] seed_of(input logic [1:0] s);
        case (s)
            S_SHIFT: seed_of = 4'b0001;
            S_BLINK: seed_of = 4'b1111;
            default: seed_of = 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] step_of(input logic [1:0] s, input logic [3:0] p);
        case (s)
            S_SHIFT: step_of = {p[2:0], p[3]};
            S_BLINK: step_of = ~p;
            S_COUNT: step_of = p + 4'd1;
            default: step_of = 4'b0000;
        endcase
    endfunction

    // A request is taken only after the previous ack has been released.
    assign w_accept = mode_req & ~r_ack;
    assign w_tick   = enable & (r_cnt == CNT_MAX);

    always_comb begin
        w_state_nxt   = r_state;
        w_pattern_nxt = r_pattern;
        w_cnt_nxt     = r_cnt;
        if (w_accept) begin
            // Acceptance overrides a coincident tick: seed loads, prescaler restarts.
            w_state_nxt   = mode_to_state(mode);
            w_pattern_nxt = seed_of(mode_to_state(mode));
            w_cnt_nxt     = '0;
        end else if (enable) begin
            w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) begin
                w_pattern_nxt = step_of(r_state, r_pattern);
            end
        end
    end

    always_comb begin
        w_ack_nxt = r_ack;
        if (w_accept) begin
            w_ack_nxt = 1'b1;
        end else if (!mode_req) begin
            w_ack_nxt = 1'b0;
        end
    end

`ifdef LED_PWM_DIM_EN
    logic [PWM_BITS-1:0] r_pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    assign w_led_mask = {4{r_pwm_cnt < duty}};
`else
    assign w_led_mask = 4'b1111;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pattern <= 4'b0000;
            r_cnt     <= '0;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
            r_led     <= 4'b0000;
        end else begin
            r_state   <= w_state_nxt;
            r_pattern <= w_pattern_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ack     <= w_ack_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_led     <= r_pattern & w_led_mask;
        end
    end

    assign mode_ack = r_ack;
    assign busy     = r_busy;
    assign led      = r_led;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: per-cycle scoreboard against a behavioural
// model, segment-end constant checks, and hand-written async-reset sequences.
module tb_led_seq_ctrl;

    localparam int CLK_HZ  = 1000;
    localparam int STEP_HZ = 100;
    localparam int DIV     = CLK_HZ / STEP_HZ;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       mode_req;
    logic [1:0] mode;
    logic       mode_ack;
    logic       busy;
    logic [3:0] led;
`ifdef LED_PWM_DIM_EN
    logic [3:0] duty;
`endif

    always #10 clk = ~clk;

    led_seq_ctrl #(.CLK_HZ(CLK_HZ), .STEP_HZ(STEP_HZ), .PWM_BITS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .mode_req (mode_req),
        .mode     (mode),
`ifdef LED_PWM_DIM_EN
        .duty     (duty),
`endif
        .mode_ack (mode_ack),
        .busy     (busy),
        .led      (led)
    );

    typedef struct {
        logic       ack;
        logic       busy;
        logic [3:0] led;
    } exp_t;

    typedef struct {
        logic       en;
        logic       req;
        logic [1:0] md;
        int         ncyc;
        logic [3:0] exp_led;
        logic       exp_ack;
        logic       exp_busy;
    } seg_t;

    exp_t q[$];
    seg_t segs[22];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [1:0] m_state;
    logic [3:0] m_pat;
    logic       m_ack;
    int         m_cnt;
    logic [3:0] m_pwm;
    logic       m_busy;
    logic [3:0] m_led;

    function automatic logic [3:0] model_seed(input logic [1:0] md);
        if (md == 2'd1) return 4'b0001;
        if (md == 2'd2) return 4'b1111;
        return 4'b0000;
    endfunction

    function automatic logic [3:0] model_step(input logic [1:0] st, input logic [3:0] p);
        case (st)
            2'd1:    return {p[2:0], p[3]};
            2'd2:    return ~p;
            2'd3:    return p + 4'd1;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 2'd0; m_pat = 4'b0; m_ack = 1'b0; m_cnt = 0;
        m_pwm = 4'b0; m_busy = 1'b0; m_led = 4'b0;
    endtask

    task automatic check_now(input string name, input exp_t e);
        n_tests++;
        if (mode_ack !== e.ack || busy !== e.busy || led !== e.led) begin
            n_fail++;
            $display("FAIL %s t=%0t: got ack=%b busy=%b led=%b, want ack=%b busy=%b led=%b",
                     name, $time, mode_ack, busy, led, e.ack, e.busy, e.led);
        end
    endtask

    // One clock: drive inputs, advance the model, push expectation, compare after the edge.
    task automatic cyc(input logic en, input logic req, input logic [1:0] md);
        logic       acc;
        logic       tk;
        logic [3:0] mask;
        exp_t       e;
        exp_t       got;
        enable = en; mode_req = req; mode = md;
        acc  = req && !m_ack;
        tk   = en && (m_cnt == DIV - 1);
`ifdef LED_PWM_DIM_EN
        mask = (m_pwm < duty) ? 4'hF : 4'h0;
`else
        mask = 4'hF;
`endif
        m_led = m_pat & mask;
        if (acc) begin
            m_state = md; m_pat = model_seed(md); m_cnt = 0;
        end else if (en) begin
            m_cnt = tk ? 0 : m_cnt + 1;
            if (tk) m_pat = model_step(m_state, m_pat);
        end
        m_ack  = acc ? 1'b1 : (req ? m_ack : 1'b0);
        m_busy = (m_state != 2'd0);
        m_pwm  = m_pwm + 4'd1;
        e.ack = m_ack; e.busy = m_busy; e.led = m_led;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard_empty t=%0t: got 0 entries, want 1", $time);
        end else begin
            got = q.pop_front();
            check_now("cycle", got);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t z;
        exp_t e;
        z.ack = 1'b0; z.busy = 1'b0; z.led = 4'b0000;

        //            en  req md  ncyc  led      ack  busy
        segs[0]  = '{1'b1,1'b0,2'd0,  3, 4'b0000,1'b0,1'b0};
        segs[1]  = '{1'b1,1'b1,2'd1,  1, 4'b0000,1'b1,1'b1};
        segs[2]  = '{1'b1,1'b1,2'd1,  1, 4'b0001,1'b1,1'b1};
        segs[3]  = '{1'b1,1'b0,2'd1,  1, 4'b0001,1'b0,1'b1};
        segs[4]  = '{1'b1,1'b0,2'd1,  7, 4'b0001,1'b0,1'b1};
        segs[5]  = '{1'b1,1'b0,2'd1,  2, 4'b0010,1'b0,1'b1};
        segs[6]  = '{1'b1,1'b0,2'd1, 30, 4'b0001,1'b0,1'b1};
        segs[7]  = '{1'b1,1'b1,2'd3,  1, 4'b0001,1'b1,1'b1};
        segs[8]  = '{1'b1,1'b0,2'd3,170, 4'b0000,1'b0,1'b1};
        segs[9]  = '{1'b1,1'b0,2'd3,  9, 4'b0001,1'b0,1'b1};
        segs[10] = '{1'b1,1'b1,2'd1,  1, 4'b0001,1'b1,1'b1};
        segs[11] = '{1'b1,1'b1,2'd1,  1, 4'b0001,1'b1,1'b1};
        segs[12] = '{1'b1,1'b0,2'd1,  1, 4'b0001,1'b0,1'b1};
        segs[13] = '{1'b1,1'b1,2'd2,  1, 4'b0001,1'b1,1'b1};
        segs[14] = '{1'b1,1'b0,2'd2,  4, 4'b1111,1'b0,1'b1};
        segs[15] = '{1'b0,1'b0,2'd2, 25, 4'b1111,1'b0,1'b1};
        segs[16] = '{1'b1,1'b0,2'd2,  5, 4'b1111,1'b0,1'b1};
        segs[17] = '{1'b1,1'b0,2'd2,  2, 4'b0000,1'b0,1'b1};
        segs[18] = '{1'b0,1'b1,2'd1,  2, 4'b0001,1'b1,1'b1};
        segs[19] = '{1'b0,1'b0,2'd1,  3, 4'b0001,1'b0,1'b1};
        segs[20] = '{1'b1,1'b1,2'd0,  2, 4'b0000,1'b1,1'b0};
        segs[21] = '{1'b1,1'b0,2'd0, 12, 4'b0000,1'b0,1'b0};

        rst_n = 1'b0; enable = 1'b0; mode_req = 1'b0; mode = 2'd0;
`ifdef LED_PWM_DIM_EN
        duty = 4'hF;
`endif
        model_reset();

        // Held in reset for 100 ns; outputs must stay idle.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_now("reset_hold", z);
        end
        rst_n = 1'b1;

        for (int s = 0; s < 22; s++) begin
            for (int c = 0; c < segs[s].ncyc; c++) begin
                cyc(segs[s].en, segs[s].req, segs[s].md);
            end
            e.ack = segs[s].exp_ack; e.busy = segs[s].exp_busy; e.led = segs[s].exp_led;
`ifdef LED_PWM_DIM_EN
            e.led = m_led;
`endif
            check_now($sformatf("seg%0d_end", s), e);
        end

        // Async reset in the middle of SHIFT, away from any clock edge.
        cyc(1'b1, 1'b1, 2'd1);
        cyc(1'b1, 1'b1, 2'd1);
        for (int c = 0; c < 4; c++) cyc(1'b1, 1'b0, 2'd1);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_now("async_reset_immediate", z);
        @(negedge clk);
        check_now("async_reset_held", z);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) cyc(1'b1, 1'b0, 2'd0);
        check_now("post_reset_idle", z);

`ifdef LED_PWM_DIM_EN
        duty = 4'd4;
        cyc(1'b1, 1'b1, 2'd2);
        for (int c = 0; c < 40; c++) cyc(1'b1, 1'b0, 2'd2);
        duty = 4'd0;
        for (int c = 0; c < 32; c++) cyc(1'b1, 1'b0, 2'd2);
        check_now("pwm_duty0_dark", z);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
